// File: rtl/stream_negate_engine.sv
// Streaming two's-complement negation engine: tagged out-of-order loads,
// a pipelined lane negator and in-place stores through a credit-bounded FIFO.
module stream_negate_engine #(
  parameter int MEM_WIDTH       = 64,
  parameter int INT_WIDTH       = 32,
  parameter int NEG_LANES       = 1,
  parameter int NEG_LATENCY     = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_WIDTH      = 64,
  parameter int ADDR_STEP       = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [31:0]           num_beats,
  output logic                  busy,
  output logic                  done,
  output logic                  err_unknown_tag,
  input  logic [3:0]            mem2proc_response,
  input  logic [MEM_WIDTH-1:0]  mem2proc_data,
  input  logic [3:0]            mem2proc_tag,
  output logic [1:0]            proc2mem_command,
  output logic [ADDR_WIDTH-1:0] proc2mem_address,
  output logic [MEM_WIDTH-1:0]  proc2mem_data
);
  localparam int LPB   = MEM_WIDTH / INT_WIDTH;
  localparam int GRPS  = LPB / NEG_LANES;
  localparam int GRP_W = NEG_LANES * INT_WIDTH;
  localparam int GW    = $clog2(GRPS + 1);
  localparam int MO    = MAX_OUTSTANDING;
  localparam int SW    = (MO > 1) ? $clog2(MO) : 1;
  localparam int CW    = $clog2(MO + 1);
  localparam int UW    = CW + 1;
  localparam logic [1:0] C_NONE  = 2'd0;
  localparam logic [1:0] C_LOAD  = 2'd1;
  localparam logic [1:0] C_STORE = 2'd2;
  localparam logic [INT_WIDTH-1:0] ONE = INT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  typedef enum logic [1:0] {S_FREE, S_WAIT, S_READY, S_BUSY} slot_e;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [31:0]           r_num, r_loads, r_stores;
  logic                  r_err;

  slot_e                 r_st [MO];
  logic [3:0]            r_tag [MO];
  logic [ADDR_WIDTH-1:0] r_sa [MO];
  logic [MEM_WIDTH-1:0]  r_sd [MO];

  logic [ADDR_WIDTH-1:0] r_fa [MO];
  logic [MEM_WIDTH-1:0]  r_fd [MO];
  logic [SW-1:0]         r_wp, r_rp;
  logic [CW-1:0]         r_fcnt;

  logic                  r_uact;
  logic [SW-1:0]         r_uslot;
  logic [GW-1:0]         r_ucnt;
  logic [MEM_WIDTH-1:0]  r_asm;
  logic                  r_pv [NEG_LATENCY];
  logic [GRP_W-1:0]      r_pd [NEG_LATENCY];
  logic [GW-1:0]         r_pg [NEG_LATENCY];

  logic [UW-1:0]         w_used;
  logic [SW-1:0]         w_free_idx, w_ready_idx, w_match_idx;
  logic                  w_ready_any, w_match, w_unknown;
  logic [1:0]            w_cmd;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [MEM_WIDTH-1:0]  w_data;
  logic                  w_accept, w_ld_acc, w_st_acc;
  logic                  w_feed, w_ov, w_last;
  logic [MEM_WIDTH-1:0]  w_beat, w_asm_next;
  logic [GRP_W-1:0]      w_grp, w_neg, w_od;
  logic [GW-1:0]         w_og;

  function automatic logic [SW-1:0] inc(input logic [SW-1:0] p);
    return (p == SW'(MO - 1)) ? '0 : p + SW'(1);
  endfunction

  // Slot scan: lowest-index wins for both allocation and unpacking
  always_comb begin
    w_used      = '0;
    w_free_idx  = '0;
    w_ready_idx = '0;
    w_ready_any = 1'b0;
    w_match     = 1'b0;
    w_match_idx = '0;
    for (int i = MO - 1; i >= 0; i--) begin
      if (r_st[i] == S_FREE) w_free_idx = SW'(i);
      if (r_st[i] == S_READY) begin
        w_ready_any = 1'b1;
        w_ready_idx = SW'(i);
      end
      if (r_st[i] == S_WAIT && mem2proc_tag != 4'd0 &&
          r_tag[i] == mem2proc_tag) begin
        w_match     = 1'b1;
        w_match_idx = SW'(i);
      end
      if (r_st[i] != S_FREE) w_used = w_used + UW'(1);
    end
    w_used    = w_used + UW'(r_fcnt);
    w_unknown = mem2proc_tag != 4'd0 && !w_match &&
                (r_state == RUN || r_state == DRAIN);
  end

  always_comb begin
    w_cmd  = C_NONE;
    w_addr = '0;
    w_data = '0;
    if (r_state == RUN || r_state == DRAIN) begin
      if (r_fcnt != '0) begin
        w_cmd  = C_STORE;
        w_addr = r_fa[r_rp];
        w_data = r_fd[r_rp];
      end else if (r_state == RUN && r_loads != r_num &&
                   w_used < UW'(MO)) begin
        w_cmd  = C_LOAD;
        w_addr = r_base + ADDR_WIDTH'(r_loads) * ADDR_WIDTH'(ADDR_STEP);
      end
    end
    w_accept = w_cmd != C_NONE && mem2proc_response != 4'd0;
    w_ld_acc = w_accept && w_cmd == C_LOAD;
    w_st_acc = w_accept && w_cmd == C_STORE;
  end

  always_comb begin
    w_beat = r_sd[r_uslot];
    w_feed = r_uact && r_ucnt != GW'(GRPS);
    w_grp  = '0;
    for (int g = 0; g < GRPS; g++)
      if (r_ucnt == GW'(g)) w_grp = w_beat[g*GRP_W +: GRP_W];
    w_neg = '0;
    for (int l = 0; l < NEG_LANES; l++)
      w_neg[l*INT_WIDTH +: INT_WIDTH] =
        ~w_grp[l*INT_WIDTH +: INT_WIDTH] + ONE;
    w_ov = r_pv[NEG_LATENCY-1];
    w_od = r_pd[NEG_LATENCY-1];
    w_og = r_pg[NEG_LATENCY-1];
    w_asm_next = r_asm;
    for (int g = 0; g < GRPS; g++)
      if (w_og == GW'(g)) w_asm_next[g*GRP_W +: GRP_W] = w_od;
    w_last = w_ov && w_og == GW'(GRPS - 1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_base   <= '0;
      r_num    <= '0;
      r_loads  <= '0;
      r_stores <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_unknown) r_err <= 1'b1;
      if (w_ld_acc) r_loads <= r_loads + 32'd1;
      if (w_st_acc) r_stores <= r_stores + 32'd1;
      unique case (r_state)
        IDLE: if (start) begin
          r_base   <= base_addr;
          r_num    <= num_beats;
          r_loads  <= '0;
          r_stores <= '0;
          r_err    <= 1'b0;
          r_state  <= (num_beats == 32'd0) ? DONE : RUN;
        end
        RUN:   if (r_loads == r_num) r_state <= DRAIN;
        DRAIN: if (r_stores == r_num) r_state <= DONE;
        DONE:  r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MO; i++) begin
        r_st[i]  <= S_FREE;
        r_tag[i] <= '0;
        r_sa[i]  <= '0;
        r_sd[i]  <= '0;
        r_fa[i]  <= '0;
        r_fd[i]  <= '0;
      end
      for (int i = 0; i < NEG_LATENCY; i++) begin
        r_pv[i] <= 1'b0;
        r_pd[i] <= '0;
        r_pg[i] <= '0;
      end
      r_wp    <= '0;
      r_rp    <= '0;
      r_fcnt  <= '0;
      r_uact  <= 1'b0;
      r_uslot <= '0;
      r_ucnt  <= '0;
      r_asm   <= '0;
    end else begin
      if (w_match) begin
        r_sd[w_match_idx] <= mem2proc_data;
        r_st[w_match_idx] <= S_READY;
      end
      if (w_ld_acc) begin
        r_st[w_free_idx]  <= S_WAIT;
        r_tag[w_free_idx] <= mem2proc_response;
        r_sa[w_free_idx]  <= w_addr;
      end
      if (!r_uact && w_ready_any) begin
        r_uact            <= 1'b1;
        r_uslot           <= w_ready_idx;
        r_ucnt            <= '0;
        r_st[w_ready_idx] <= S_BUSY;
      end else if (w_feed) begin
        r_ucnt <= r_ucnt + GW'(1);
      end
      r_pv[0] <= w_feed;
      r_pd[0] <= w_neg;
      r_pg[0] <= r_ucnt;
      for (int i = 1; i < NEG_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pd[i] <= r_pd[i-1];
        r_pg[i] <= r_pg[i-1];
      end
      if (w_ov) r_asm <= w_asm_next;
      // Final lane: beat leaves its slot for the FIFO, credit stays constant
      if (w_last) begin
        r_fa[r_wp]    <= r_sa[r_uslot];
        r_fd[r_wp]    <= w_asm_next;
        r_wp          <= inc(r_wp);
        r_st[r_uslot] <= S_FREE;
        r_uact        <= 1'b0;
      end
      if (w_st_acc) r_rp <= inc(r_rp);
      if (w_last && !w_st_acc) r_fcnt <= r_fcnt + CW'(1);
      else if (!w_last && w_st_acc) r_fcnt <= r_fcnt - CW'(1);
    end
  end

  assign busy             = r_state == RUN || r_state == DRAIN;
  assign done             = r_state == DONE;
  assign err_unknown_tag  = r_err;
  assign proc2mem_command = w_cmd;
  assign proc2mem_address = w_addr;
  assign proc2mem_data    = w_data;
endmodule

// File: tb/tb_stream_negate_engine.sv
// Bench for stream_negate_engine: randomized tagged memory model with
// out-of-order returns and an address-keyed store scoreboard.
`timescale 1ns/1ps
module tb_stream_negate_engine;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] base_addr = '0;
  logic [31:0] num_beats = '0;
  logic        busy, done, err_unknown_tag;
  logic [3:0]  mem2proc_response = '0;
  logic [63:0] mem2proc_data = '0;
  logic [3:0]  mem2proc_tag = '0;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_address, proc2mem_data;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [3:0] tag; logic [63:0] addr; } pend_t;
  pend_t       pend [$];
  logic [63:0] mem [logic [63:0]];
  logic [63:0] exp_st [logic [63:0]];
  bit          tag_used [16];
  int          p_acc = 100, p_ret = 100, max_pend = 15, stall_left = 0;
  bit          hold = 1'b0;
  int          ret_order [$];
  logic [3:0]  inj_tag = '0;
  logic [1:0]  snap_cmd;
  logic [63:0] snap_addr, snap_data;
  int          occ = 0;

  stream_negate_engine dut (
    .clock(clock), .reset(reset), .start(start),
    .base_addr(base_addr), .num_beats(num_beats),
    .busy(busy), .done(done), .err_unknown_tag(err_unknown_tag),
    .mem2proc_response(mem2proc_response),
    .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
    .proc2mem_command(proc2mem_command),
    .proc2mem_address(proc2mem_address),
    .proc2mem_data(proc2mem_data)
  );

  always #5 clock = ~clock;

  function automatic void check(input string nm, input logic [63:0] act,
                                input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endfunction

  function automatic void fail_now(input string nm, input logic [63:0] v);
    n_tests++;
    n_fail++;
    $display("FAIL %s: value 0x%0h", nm, v);
  endfunction

  function automatic logic [63:0] rd(input logic [63:0] a);
    if (!mem.exists(a)) mem[a] = {$urandom, $urandom};
    return mem[a];
  endfunction

  // Reference: each 32-bit lane becomes (2^32 - x) mod 2^32
  function automatic logic [63:0] negbeat(input logic [63:0] v);
    logic [63:0] r, x;
    r = '0;
    for (int l = 0; l < 2; l++) begin
      x = (v >> (32 * l)) & 64'hFFFF_FFFF;
      x = (64'h1_0000_0000 - x) % 64'h1_0000_0000;
      r = r | (x << (32 * l));
    end
    return r;
  endfunction

  // Memory model: accepts commands, assigns tags, returns loads out of order
  initial forever begin : mm
    int n, k;
    logic [3:0] t;
    @(negedge clock);
    mem2proc_response = '0;
    mem2proc_tag = '0;
    mem2proc_data = '0;
    n = pend.size();
    if (proc2mem_command != 2'd0) begin
      if (proc2mem_command == 2'd2 && stall_left > 0) begin
        if (stall_left == 5) begin
          snap_cmd  = proc2mem_command;
          snap_addr = proc2mem_address;
          snap_data = proc2mem_data;
        end else begin
          check("bp_cmd_held", proc2mem_command, snap_cmd);
          check("bp_addr_held", proc2mem_address, snap_addr);
          check("bp_data_held", proc2mem_data, snap_data);
        end
        stall_left--;
      end else if ($urandom_range(99) < p_acc &&
                   !(proc2mem_command == 2'd1 && n >= max_pend)) begin
        t = '0;
        for (int i = 15; i >= 1; i--) if (!tag_used[i]) t = 4'(i);
        if (t != 4'd0) begin
          mem2proc_response = t;
          if (proc2mem_command == 2'd1) begin
            tag_used[t] = 1'b1;
            pend.push_back('{t, proc2mem_address});
          end
        end
      end
    end
    k = -1;
    if (inj_tag != 4'd0) begin
      mem2proc_tag  = inj_tag;
      mem2proc_data = {$urandom, $urandom};
      inj_tag = '0;
    end else if (!hold && n > 0) begin
      if (ret_order.size() > 0) begin
        for (int i = 0; i < n; i++)
          if (pend[i].tag == 4'(ret_order[0])) k = i;
        if (k >= 0) void'(ret_order.pop_front());
      end else if ($urandom_range(99) < p_ret) begin
        k = $urandom_range(n - 1);
      end
      if (k >= 0) begin
        mem2proc_tag  = pend[k].tag;
        mem2proc_data = rd(pend[k].addr);
        tag_used[pend[k].tag] = 1'b0;
        pend.delete(k);
      end
    end
  end

  // Monitor: scoreboard on accepted stores, credit bound on loads
  initial forever begin : mon
    @(negedge clock);
    #2;
    if (proc2mem_command != 2'd2)
      check("data_zero_not_store", proc2mem_data, 64'h0);
    if (mem2proc_response != 4'd0 && proc2mem_command == 2'd1) begin
      occ++;
      check("occupancy_le_4", 64'(occ <= 4), 64'h1);
    end
    if (mem2proc_response != 4'd0 && proc2mem_command == 2'd2) begin
      occ--;
      if (exp_st.exists(proc2mem_address)) begin
        check("store_data", proc2mem_data, exp_st[proc2mem_address]);
        exp_st.delete(proc2mem_address);
      end else begin
        fail_now("store_unexpected_addr", proc2mem_address);
      end
      mem[proc2mem_address] = proc2mem_data;
    end
  end

  task automatic run_job(input logic [63:0] base, input int n,
                         input string nm);
    bit seen;
    for (int i = 0; i < n; i++)
      if (!exp_st.exists(base + 64'(i)))
        exp_st[base + 64'(i)] = negbeat(rd(base + 64'(i)));
    occ = 0;
    @(negedge clock);
    base_addr = base;
    num_beats = 32'(n);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      #3;
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!seen) begin
      fail_now({nm, "_done_timeout"}, 64'(n));
    end else begin
      @(negedge clock);
      #3;
      check({nm, "_done_one_cycle"}, 64'(done), 64'h0);
      check({nm, "_idle_after"}, 64'(busy), 64'h0);
      check({nm, "_all_stores"}, 64'(exp_st.size()), 64'h0);
    end
    exp_st.delete();
  endtask

  initial begin
    bit bad_cmd;
    repeat (3) @(negedge clock);
    #3;
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_err", 64'(err_unknown_tag), 64'h0);
    check("rst_cmd", 64'(proc2mem_command), 64'h0);
    check("rst_addr", proc2mem_address, 64'h0);
    check("rst_data", proc2mem_data, 64'h0);
    @(negedge clock);
    reset = 1'b0;

    mem[64'h100] = 64'h00000005_FFFFFFFE;
    exp_st[64'h100] = 64'hFFFFFFFB_00000002;
    run_job(64'h100, 1, "single");

    mem[64'h200] = 64'h80000000_00000000;
    exp_st[64'h200] = 64'h80000000_00000000;
    run_job(64'h200, 1, "wrap");

    run_job(64'h300, 0, "zero");

    hold = 1'b1;
    fork
      run_job(64'h400, 4, "ooo");
      begin
        for (int c = 0; c < 300 && pend.size() < 4; c++) @(negedge clock);
        check("ooo_four_pending", 64'(pend.size()), 64'h4);
        ret_order = '{4, 2, 1, 3};
        hold = 1'b0;
      end
    join
    check("ooo_order_consumed", 64'(ret_order.size()), 64'h0);
    ret_order.delete();

    stall_left = 5;
    run_job(64'h500, 2, "bp");
    check("bp_stall_used", 64'(stall_left), 64'h0);

    fork
      run_job(64'h600, 3, "unk");
      begin
        repeat (3) @(negedge clock);
        inj_tag = 4'd9;
        repeat (3) @(negedge clock);
        #3;
        check("err_set", 64'(err_unknown_tag), 64'h1);
      end
    join
    check("err_sticky", 64'(err_unknown_tag), 64'h1);
    run_job(64'h700, 1, "clr");
    check("err_cleared", 64'(err_unknown_tag), 64'h0);

    hold = 1'b1;
    max_pend = 2;
    @(negedge clock);
    base_addr = 64'h800;
    num_beats = 32'd8;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 0; c < 300 && pend.size() < 2; c++) @(negedge clock);
    check("rst_two_pending", 64'(pend.size()), 64'h2);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #3;
    check("midrst_cmd", 64'(proc2mem_command), 64'h0);
    check("midrst_addr", proc2mem_address, 64'h0);
    check("midrst_data", proc2mem_data, 64'h0);
    check("midrst_busy", 64'(busy), 64'h0);
    check("midrst_done", 64'(done), 64'h0);
    reset = 1'b0;
    hold = 1'b0;
    max_pend = 15;
    bad_cmd = 1'b0;
    repeat (10) begin
      @(negedge clock);
      #3;
      if (proc2mem_command != 2'd0) bad_cmd = 1'b1;
    end
    check("midrst_no_cmd", 64'(bad_cmd), 64'h0);
    check("midrst_no_err", 64'(err_unknown_tag), 64'h0);
    check("midrst_returns_drained", 64'(pend.size()), 64'h0);

    for (int j = 0; j < 8; j++) begin
      p_acc = $urandom_range(100, 30);
      p_ret = $urandom_range(100, 20);
      run_job({32'h0, $urandom}, $urandom_range(12, 1), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
